// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and taken-branch flush steering for the
// five-stage MIPS pipeline, with saturating stall/flush event counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no pending operation; default steering, watch for lu/br_taken
// STALL | holding PC and IF/ID while a load's data becomes forwardable
// FLUSH | squashing wrong-path IF/ID slots after a taken branch/jump
module hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              br_taken,
  output logic              hazard,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // The first stall/flush cycle happens in IDLE, so the counter covers the rest.
  localparam logic [2:0] LD_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] BR_RELOAD = 3'(BR_FLUSH - 1);

  logic [1:0] state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       lu;
  logic       do_stall, do_flush;

  assign lu = id_valid & ex_load & (ex_rd != '0) &
              ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

  // Select which steering pattern this cycle drives; br_taken always wins.
  always_comb begin
    do_stall = 1'b0;
    do_flush = 1'b0;
    case (state)
      S_IDLE: begin
        if (br_taken)  do_flush = 1'b1;
        else if (lu)   do_stall = 1'b1;
      end
      S_STALL: begin
        if (br_taken)  do_flush = 1'b1;
        else           do_stall = 1'b1;
      end
      S_FLUSH:         do_flush = 1'b1;
      default: ;
    endcase
  end

  // Pipeline steering outputs; reset forces a safe bubble/flush pattern.
  always_comb begin
    hazard     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (rst) begin
      hazard     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end else if (do_flush) begin
      hazard     = 1'b1;
      ifid_flush = 1'b1;
    end else if (do_stall) begin
      hazard     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  assign busy = ~rst & (state != S_IDLE);

  // Next-state and down-counter; terminal count at rem==1 returns to IDLE.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      S_IDLE: begin
        if (br_taken) begin
          if (BR_FLUSH > 1) begin
            state_nxt = S_FLUSH;
            rem_nxt   = BR_RELOAD;
          end
        end else if (lu) begin
          if (LOAD_LAT > 1) begin
            state_nxt = S_STALL;
            rem_nxt   = LD_RELOAD;
          end
        end
      end
      S_STALL, S_FLUSH: begin
        if (br_taken) begin
          if (BR_FLUSH > 1) begin
            state_nxt = S_FLUSH;
            rem_nxt   = BR_RELOAD;
          end else begin
            state_nxt = S_IDLE;
            rem_nxt   = 3'd0;
          end
        end else if (rem <= 3'd1) begin
          state_nxt = S_IDLE;
          rem_nxt   = 3'd0;
        end else begin
          rem_nxt   = rem - 3'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        rem_nxt   = 3'd0;
      end
    endcase
  end

  // State and remaining-cycle register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Saturating performance counters; they hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
